// File: rtl/bash_fetch_pkg.sv
// Shared definitions for the expand-stage bias sequencer: word geometry,
// FSM state encoding and the byte-lane layout of one group word.
package bash_pkg;

  localparam int BASH_W       = 8;
  localparam int GROUP_CH     = 4;
  localparam int GROUP_WORD_W = 64;

  // A group word holds the four 3x3 biases in the upper half and the four
  // 1x1 biases in the lower half; channel 0 sits in the most significant byte.
  localparam int LANE_3X3_BASE = GROUP_CH * BASH_W;
  localparam int LANE_1X1_BASE = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PREF,
    ST_READY
  } state_t;

  // LSB position of the bias byte for a given channel of either kernel type.
  function automatic int lane_lsb(input logic is_3x3, input int ch);
    return (is_3x3 ? LANE_3X3_BASE : LANE_1X1_BASE) + (GROUP_CH - 1 - ch) * BASH_W;
  endfunction

endpackage

// File: rtl/bash_fetch_if.sv
// Load stream, group-advance and bias-bus signals of the bias sequencer.
// The slave side is the sequencer itself; the master side is the
// configuration/DMA stream plus the consumer that issues group advances.
interface bash_fetch_if #(
  parameter int ADDR_W = 6
);
  import bash_pkg::*;

  logic                    load_start_i;
  logic [ADDR_W:0]         layer_groups_i;
  logic                    bias_en_i;
  logic [GROUP_WORD_W-1:0] load_data_i;
  logic                    load_valid_i;
  logic                    load_ready_o;
  logic                    load_done_o;
  logic                    group_next_i;
  logic [GROUP_WORD_W-1:0] bash_2_o;
  logic                    bash_valid_o;
  logic                    add_en_o;

  modport master (
    output load_start_i, layer_groups_i, bias_en_i, load_data_i, load_valid_i, group_next_i,
    input  load_ready_o, load_done_o, bash_2_o, bash_valid_o, add_en_o
  );

  modport slave (
    input  load_start_i, layer_groups_i, bias_en_i, load_data_i, load_valid_i, group_next_i,
    output load_ready_o, load_done_o, bash_2_o, bash_valid_o, add_en_o
  );

endinterface

// File: rtl/bash_fetch_ram.sv
// Simple dual-port bias store with a registered read so it maps onto block RAM.
// Contents are deliberately not reset.
module bash_ram
  import bash_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [GROUP_WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [GROUP_WORD_W-1:0] rd_data
);

  logic [GROUP_WORD_W-1:0] mem [DEPTH];

  // Write port and one-cycle registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bash_fetch.sv
// Bias sequencer: buffers one layer's group bias words, then replays them in
// order (wrapping per output row) on the bias bus that feeds the expand adder.
module bash_fetch
  import bash_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  bash_fetch_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  state_t                  state, state_nxt;
  logic [ADDR_W:0]         n_groups, n_groups_nxt;
  logic                    bias_en, bias_en_nxt;
  logic [ADDR_W-1:0]       wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0]       rd_ptr, rd_ptr_nxt;
  logic                    wr_en;
  logic [GROUP_WORD_W-1:0] rd_data;
  logic [ADDR_W:0]         clamped;
  logic                    last_beat;
  logic                    last_rd;

  assign clamped   = (bus.layer_groups_i > DEPTH_CNT) ? DEPTH_CNT : bus.layer_groups_i;
  assign last_beat = ({1'b0, wr_ptr} == (n_groups - 1'b1));
  assign last_rd   = ({1'b0, rd_ptr} == (n_groups - 1'b1));

  // The read address is the next-pointer value so an advance shows up one cycle later.
  bash_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk_i),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (bus.load_data_i),
    .rd_addr (rd_ptr_nxt),
    .rd_data (rd_data)
  );

  // State, latched layer config and pointers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      n_groups <= '0;
      bias_en  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      n_groups <= n_groups_nxt;
      bias_en  <= bias_en_nxt;
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
    end
  end

  // Next-state logic; a load start always wins over beats and group advances.
  always_comb begin
    state_nxt    = state;
    n_groups_nxt = n_groups;
    bias_en_nxt  = bias_en;
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    wr_en        = 1'b0;
    if (bus.load_start_i) begin
      n_groups_nxt = clamped;
      bias_en_nxt  = bus.bias_en_i;
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      state_nxt    = (clamped == '0) ? ST_PREF : ST_LOAD;
    end else begin
      case (state)
        ST_LOAD: begin
          if (bus.load_valid_i) begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + 1'b1;
            if (last_beat) begin
              state_nxt = ST_PREF;
            end
          end
        end
        ST_PREF: begin
          rd_ptr_nxt = '0;
          state_nxt  = ST_READY;
        end
        ST_READY: begin
          if (bus.group_next_i && (n_groups != '0)) begin
            rd_ptr_nxt = last_rd ? '0 : rd_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.load_ready_o = (state == ST_LOAD);
  assign bus.load_done_o  = (state == ST_PREF);
  assign bus.bash_valid_o = (state == ST_READY);
  assign bus.add_en_o     = (state == ST_READY) && bias_en && (n_groups != '0);
  assign bus.bash_2_o     = ((state == ST_READY) && (n_groups != '0)) ? rd_data : '0;

endmodule

// File: tb/tb_bash_fetch.sv
// Self-checking bench for bash_fetch: directed scenarios with literal
// expectations plus randomized layers, all compared every cycle against a
// queue-based reference model of the sequencer's behaviour.
module tb_bash_fetch;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [63:0] layer_words [DEPTH];

  bash_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  bash_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: the stored layer as a queue and a replay index.
  logic [63:0] got [$];
  int need         = 0;
  bit ben          = 1'b0;
  bit loading      = 1'b0;
  bit done_pending = 1'b0;
  bit running      = 1'b0;
  int idx          = 0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
    end
  endtask

  // Model update at each active edge (or asynchronous reset).
  initial begin
    forever begin
      @(posedge clk_i or negedge rst_n_i);
      if (!rst_n_i) begin
        got.delete();
        need = 0; ben = 1'b0; loading = 1'b0; done_pending = 1'b0; running = 1'b0; idx = 0;
      end else if (bus.load_start_i) begin
        need    = (int'(bus.layer_groups_i) > DEPTH) ? DEPTH : int'(bus.layer_groups_i);
        ben     = bus.bias_en_i;
        got.delete();
        running = 1'b0;
        idx     = 0;
        loading = (need != 0);
        done_pending = (need == 0);
      end else if (loading) begin
        if (bus.load_valid_i) begin
          got.push_back(bus.load_data_i);
          if (got.size() == need) begin
            loading = 1'b0;
            done_pending = 1'b1;
          end
        end
      end else if (done_pending) begin
        done_pending = 1'b0;
        running = 1'b1;
      end else if (running && bus.group_next_i && need > 0) begin
        idx = (idx + 1) % need;
      end
    end
  end

  // Compare every DUT output against the model on the falling edge.
  initial begin
    logic [63:0] exp_word;
    forever begin
      @(negedge clk_i);
      if (rst_n_i) begin
        exp_word = (running && need > 0) ? got[idx] : 64'h0;
        check_output("model_load_ready", 64'(bus.load_ready_o), 64'(loading));
        check_output("model_load_done",  64'(bus.load_done_o),  64'(done_pending));
        check_output("model_bash_valid", 64'(bus.bash_valid_o), 64'(running));
        check_output("model_add_en",     64'(bus.add_en_o),     64'(running && ben && need > 0));
        check_output("model_bash_word",  bus.bash_2_o,          exp_word);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_load(input int groups, input bit en);
    bus.load_start_i   = 1'b1;
    bus.layer_groups_i = (ADDR_W + 1)'(groups);
    bus.bias_en_i      = en;
    tick();
    bus.load_start_i   = 1'b0;
  endtask

  // mode 0: valid every cycle, 1: every other cycle, 2: random gaps.
  task automatic apply_stimulus(input int count, input int mode, input bit stray);
    int sent;
    int budget;
    int cyc;
    bit v;
    sent = 0; budget = 4 * count + 20; cyc = 0;
    while (sent < count && budget > 0) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.load_valid_i = v;
      bus.load_data_i  = v ? layer_words[sent] : {$urandom, $urandom};
      bus.group_next_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      if (v && bus.load_ready_o) sent++;
      tick();
      cyc++;
      budget--;
    end
    bus.load_valid_i = 1'b0;
    bus.group_next_i = 1'b0;
    check_output("beats_accepted", 64'(sent), 64'(count));
  endtask

  task automatic pulse_next();
    bus.group_next_i = 1'b1;
    tick();
    bus.group_next_i = 1'b0;
  endtask

  initial begin
    logic [63:0] basic_exp [4];
    int g;
    int cnt;
    int w;
    bit en;

    basic_exp[0] = 64'h0202020202020202;
    basic_exp[1] = 64'h0303030303030303;
    basic_exp[2] = 64'h0404040404040404;
    basic_exp[3] = 64'h0101010101010101;

    bus.load_start_i = 1'b0; bus.layer_groups_i = '0; bus.bias_en_i = 1'b0;
    bus.load_data_i  = '0;   bus.load_valid_i   = 1'b0; bus.group_next_i = 1'b0;

    repeat (3) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    tick();

    // Reset asserted in the middle of a load.
    for (int i = 0; i < 8; i++) layer_words[i] = {$urandom, $urandom};
    start_load(8, 1'b1);
    apply_stimulus(3, 0, 1'b0);
    check_output("ready_mid_load", 64'(bus.load_ready_o), 64'd1);
    rst_n_i = 1'b0;
    #1;
    check_output("rst_ready", 64'(bus.load_ready_o), 64'd0);
    check_output("rst_done",  64'(bus.load_done_o),  64'd0);
    check_output("rst_valid", 64'(bus.bash_valid_o), 64'd0);
    check_output("rst_add_en", 64'(bus.add_en_o),    64'd0);
    check_output("rst_word",  bus.bash_2_o,          64'd0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    tick();
    check_output("idle_ready", 64'(bus.load_ready_o), 64'd0);
    check_output("idle_valid", 64'(bus.bash_valid_o), 64'd0);

    // Basic four-group load and wrapping replay.
    for (int i = 0; i < 4; i++) layer_words[i] = {8{8'(i + 1)}};
    start_load(4, 1'b1);
    apply_stimulus(4, 0, 1'b0);
    check_output("basic_done", 64'(bus.load_done_o), 64'd1);
    tick();
    check_output("basic_word0", bus.bash_2_o, 64'h0101010101010101);
    check_output("basic_add_en", 64'(bus.add_en_o), 64'd1);
    for (int k = 0; k < 4; k++) begin
      pulse_next();
      check_output($sformatf("basic_next%0d", k), bus.bash_2_o, basic_exp[k]);
    end

    // Gapped beats with stray group advances during the load.
    for (int i = 0; i < 6; i++) layer_words[i] = {$urandom, $urandom};
    start_load(6, 1'b1);
    apply_stimulus(6, 1, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin
      check_output($sformatf("gap_word%0d", k), bus.bash_2_o, layer_words[k]);
      pulse_next();
    end
    check_output("gap_wrap", bus.bash_2_o, layer_words[0]);

    // Group count above DEPTH is clamped to DEPTH.
    for (int i = 0; i < DEPTH; i++) layer_words[i] = {$urandom, $urandom};
    start_load(80, 1'b1);
    apply_stimulus(DEPTH, 0, 1'b0);
    check_output("clamp_done", 64'(bus.load_done_o), 64'd1);
    tick();
    bus.group_next_i = 1'b1;
    repeat (DEPTH - 1) tick();
    bus.group_next_i = 1'b0;
    check_output("clamp_word63", bus.bash_2_o, layer_words[DEPTH - 1]);
    pulse_next();
    check_output("clamp_wrap", bus.bash_2_o, layer_words[0]);

    // Empty layer.
    start_load(0, 1'b1);
    check_output("empty_done", 64'(bus.load_done_o), 64'd1);
    check_output("empty_ready", 64'(bus.load_ready_o), 64'd0);
    tick();
    check_output("empty_valid", 64'(bus.bash_valid_o), 64'd1);
    check_output("empty_word", bus.bash_2_o, 64'd0);
    check_output("empty_add_en", 64'(bus.add_en_o), 64'd0);

    // Bias disabled layer.
    for (int i = 0; i < 3; i++) layer_words[i] = {$urandom, $urandom};
    start_load(3, 1'b0);
    apply_stimulus(3, 2, 1'b0);
    tick();
    check_output("nobias_valid", 64'(bus.bash_valid_o), 64'd1);
    check_output("nobias_add_en", 64'(bus.add_en_o), 64'd0);
    check_output("nobias_word0", bus.bash_2_o, layer_words[0]);

    // Reload while a group advance is requested in the same cycle.
    pulse_next();
    check_output("reload_pre_word1", bus.bash_2_o, layer_words[1]);
    layer_words[0] = {$urandom, $urandom};
    layer_words[1] = {$urandom, $urandom};
    bus.group_next_i = 1'b1;
    start_load(2, 1'b1);
    bus.group_next_i = 1'b0;
    check_output("reload_valid", 64'(bus.bash_valid_o), 64'd0);
    check_output("reload_ready", 64'(bus.load_ready_o), 64'd1);
    apply_stimulus(2, 0, 1'b0);
    tick();
    check_output("reload_word0", bus.bash_2_o, layer_words[0]);

    // Randomized layers, occasionally restarted mid-load.
    repeat (8) begin
      g   = $urandom_range(0, 70);
      en  = 1'($urandom_range(0, 1));
      cnt = (g > DEPTH) ? DEPTH : g;
      for (int i = 0; i < DEPTH; i++) layer_words[i] = {$urandom, $urandom};
      start_load(g, en);
      if (cnt > 2 && $urandom_range(0, 2) == 0) begin
        apply_stimulus(cnt / 2, 2, 1'b1);
        start_load(g, en);
      end
      if (cnt > 0) apply_stimulus(cnt, 2, 1'b1);
      w = 0;
      while (!bus.bash_valid_o && w < 5) begin
        tick();
        w++;
      end
      check_output("rand_reach_ready", 64'(bus.bash_valid_o), 64'd1);
      repeat ($urandom_range(10, 80)) begin
        bus.group_next_i = 1'($urandom_range(0, 1));
        tick();
      end
      bus.group_next_i = 1'b0;
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
